wb_data_interconnect: RTL and testbench

Parametrised successor to the fixed five-way data-bus decode in the SoC top: a single-master, N-slave Wishbone classic interconnect with per-slave base/mask windows. It replaces the combinational `*_sel` ternary decode and response muxes. It adds behaviour the fixed decode lacks:
- registered grant
- decode-error response for unmapped addresses
- per-transaction timeout with error
- master-abort handling
- sticky fault address/count status for the protection/debug path

It sits between the CPU data bus and the memory/peripheral macros.

---
 rtl/wb_ic_pkg.sv | 44 ++++
 rtl/wb_ic_decoder.sv | 45 ++++
 rtl/wb_data_interconnect.sv | 195 +++++++++++++++++++
 tb/tb_wb_data_interconnect.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_ic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_ic_pkg
//  Brief    : Shared types and SoC memory-map constants for the Wishbone
//             data-bus interconnect.
//  Revision : 1.0  initial release
// ============================================================================
package wb_ic_pkg;

    // Transaction FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2,
        ST_DECERR = 2'd3
    } ic_state_t;

    // Default SoC memory map
    localparam logic [31:0] c_mem_base  = 32'h0000_0000;
    localparam logic [31:0] c_mem_mask  = 32'hE000_0000;
    localparam logic [31:0] c_pwm_base  = 32'h4000_0000;
    localparam logic [31:0] c_pwm_mask  = 32'hFFFF_0000;
    localparam logic [31:0] c_adc_base  = 32'h4001_0000;
    localparam logic [31:0] c_adc_mask  = 32'hFFFF_0000;
    localparam logic [31:0] c_prot_base = 32'h4002_0000;
    localparam logic [31:0] c_prot_mask = 32'hFFFF_0000;
    localparam logic [31:0] c_comm_base = 32'h4003_0000;
    localparam logic [31:0] c_comm_mask = 32'hFFFF_0000;

    // Slave port indices in the default map
    localparam int c_slv_mem  = 0;
    localparam int c_slv_pwm  = 1;
    localparam int c_slv_adc  = 2;
    localparam int c_slv_prot = 3;
    localparam int c_slv_comm = 4;

    // Flattened default windows, slave 0 in the least significant word
    localparam logic [5*32-1:0] c_default_base =
        {c_comm_base, c_prot_base, c_adc_base, c_pwm_base, c_mem_base};
    localparam logic [5*32-1:0] c_default_mask =
        {c_comm_mask, c_prot_mask, c_adc_mask, c_pwm_mask, c_mem_mask};

endpackage
`default_nettype wire

// File: rtl/wb_ic_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : wb_ic_decoder
//  Brief    : Base/mask address compare for every slave window, followed by a
//             priority encoder (lowest index wins) giving a one-hot hit and a
//             miss flag.
//  Revision : 1.0  initial release
// ============================================================================
module wb_ic_decoder
    import wb_ic_pkg::*;
#(
    parameter int                         N_SLAVES = 5,
    parameter int                         ADDR_W   = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0]   i_adr,
    output logic [N_SLAVES-1:0] o_hit,
    output logic                o_miss
);

    logic [N_SLAVES-1:0] w_match;

    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_cmp
            assign w_match[gi] =
                ((i_adr & SLV_MASK[gi*ADDR_W +: ADDR_W]) == SLV_BASE[gi*ADDR_W +: ADDR_W]);
        end
    endgenerate

    // Priority encode: scan downward so the lowest matching index is kept
    always_comb begin
        o_hit = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit    = '0;
                o_hit[i] = 1'b1;
            end
        end
    end

    assign o_miss = ~|w_match;

endmodule
`default_nettype wire

// File: rtl/wb_data_interconnect.sv
`default_nettype none
// ============================================================================
//  Module   : wb_data_interconnect
//  Brief    : Single-master, N-slave Wishbone classic interconnect with a
//             registered grant, decode-error and timeout responses, master
//             abort handling and sticky fault address/count status.
//  Revision : 1.0  initial release
// ============================================================================
module wb_data_interconnect
    import wb_ic_pkg::*;
#(
    parameter int                         N_SLAVES       = 5,
    parameter int                         ADDR_W         = 32,
    parameter int                         DATA_W         = 32,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE       = c_default_base,
    parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK       = c_default_mask,
    parameter int                         TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    // master side
    input  logic [ADDR_W-1:0]            m_adr_i,
    input  logic [DATA_W-1:0]            m_dat_i,
    input  logic                         m_we_i,
    input  logic [DATA_W/8-1:0]          m_sel_i,
    input  logic                         m_cyc_i,
    input  logic                         m_stb_i,
    output logic [DATA_W-1:0]            m_dat_o,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    // slave side
    output logic [N_SLAVES*ADDR_W-1:0]   s_adr_o,
    output logic [N_SLAVES*DATA_W-1:0]   s_dat_o,
    output logic [N_SLAVES-1:0]          s_we_o,
    output logic [N_SLAVES*DATA_W/8-1:0] s_sel_o,
    output logic [N_SLAVES-1:0]          s_cyc_o,
    output logic [N_SLAVES-1:0]          s_stb_o,
    input  logic [N_SLAVES*DATA_W-1:0]   s_dat_i,
    input  logic [N_SLAVES-1:0]          s_ack_i,
    input  logic [N_SLAVES-1:0]          s_err_i,
    // fault status
    output logic                         timeout_irq_o,
    output logic [ADDR_W-1:0]            err_addr_o,
    output logic [15:0]                  err_count_o,
    input  logic                         err_clr_i
);

    localparam int                 c_sel_w   = DATA_W / 8;
    localparam int                 c_cnt_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_tmo_max = c_cnt_w'(TIMEOUT_CYCLES);

    ic_state_t           r_state;
    ic_state_t           w_state_nxt;
    logic [N_SLAVES-1:0] r_grant;
    logic [c_cnt_w-1:0]  r_tmo_cnt;

    logic [N_SLAVES-1:0] w_hit;
    logic                w_miss;
    logic [N_SLAVES-1:0] w_slv_en;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_slv_ack;
    logic                w_slv_err;

    logic                w_grant_load;
    logic                w_set_ack;
    logic                w_set_err;
    logic                w_timeout;
    logic                w_fault;

    wb_ic_decoder #(
        .N_SLAVES (N_SLAVES),
        .ADDR_W   (ADDR_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decoder (
        .i_adr  (m_adr_i),
        .o_hit  (w_hit),
        .o_miss (w_miss)
    );

    // Route the master request only to the granted slave while ACTIVE
    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slv
            assign w_slv_en[gi]                    = (r_state == ST_ACTIVE) && r_grant[gi];
            assign s_cyc_o[gi]                     = w_slv_en[gi] & m_cyc_i;
            assign s_stb_o[gi]                     = w_slv_en[gi] & m_cyc_i;
            assign s_we_o[gi]                      = w_slv_en[gi] & m_we_i;
            assign s_adr_o[gi*ADDR_W +: ADDR_W]    = w_slv_en[gi] ? m_adr_i : '0;
            assign s_dat_o[gi*DATA_W +: DATA_W]    = w_slv_en[gi] ? m_dat_i : '0;
            assign s_sel_o[gi*c_sel_w +: c_sel_w]  = w_slv_en[gi] ? m_sel_i : '0;
        end
    endgenerate

    // Response mux: only the granted slave's ack/err/data are visible
    always_comb begin
        w_rd_data = '0;
        w_slv_ack = 1'b0;
        w_slv_err = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (r_grant[i]) begin
                w_rd_data = w_rd_data | s_dat_i[i*DATA_W +: DATA_W];
                w_slv_ack = w_slv_ack | s_ack_i[i];
                w_slv_err = w_slv_err | s_err_i[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next state and per-cycle control decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_load = 1'b0;
        w_set_ack    = 1'b0;
        w_set_err    = 1'b0;
        w_timeout    = 1'b0;
        w_fault      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    if (w_miss) begin
                        w_state_nxt = ST_DECERR;
                        w_set_err   = 1'b1;
                        w_fault     = 1'b1;
                    end else begin
                        w_state_nxt  = ST_ACTIVE;
                        w_grant_load = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                // abort beats any response arriving in the same cycle
                if (!m_cyc_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_slv_err) begin
                    w_state_nxt = ST_RESP;
                    w_set_err   = 1'b1;
                end else if (w_slv_ack) begin
                    w_state_nxt = ST_RESP;
                    w_set_ack   = 1'b1;
                end else if (r_tmo_cnt == c_tmo_max) begin
                    w_state_nxt = ST_RESP;
                    w_set_err   = 1'b1;
                    w_timeout   = 1'b1;
                    w_fault     = 1'b1;
                end
            end
            ST_RESP:   w_state_nxt = ST_IDLE;
            ST_DECERR: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant, timeout counter, response pulses and fault status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant       <= '0;
            r_tmo_cnt     <= '0;
            m_dat_o       <= '0;
            m_ack_o       <= 1'b0;
            m_err_o       <= 1'b0;
            timeout_irq_o <= 1'b0;
            err_addr_o    <= '0;
            err_count_o   <= '0;
        end else begin
            m_ack_o       <= w_set_ack;
            m_err_o       <= w_set_err;
            timeout_irq_o <= w_timeout;

            if (w_grant_load) begin
                r_grant   <= w_hit;
                r_tmo_cnt <= '0;
            end else if (r_state == ST_ACTIVE && w_state_nxt == ST_ACTIVE) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if (w_set_ack) m_dat_o <= w_rd_data;

            if (w_fault) err_addr_o <= m_adr_i;

            // a clear that lands on a fault still counts that fault
            if (err_clr_i) begin
                err_count_o <= w_fault ? 16'd1 : 16'd0;
            end else if (w_fault && err_count_o != 16'hFFFF) begin
                err_count_o <= err_count_o + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_data_interconnect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_data_interconnect
//  Brief    : Directed self-checking bench for wb_data_interconnect.
//             Cycle 0 is the cycle in which a request is first driven.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_data_interconnect;

    localparam int N  = 5;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk;
    logic              rst;
    logic [AW-1:0]     m_adr_i;
    logic [DW-1:0]     m_dat_i;
    logic              m_we_i;
    logic [DW/8-1:0]   m_sel_i;
    logic              m_cyc_i;
    logic              m_stb_i;
    logic [DW-1:0]     m_dat_o;
    logic              m_ack_o;
    logic              m_err_o;
    logic [N*AW-1:0]   s_adr_o;
    logic [N*DW-1:0]   s_dat_o;
    logic [N-1:0]      s_we_o;
    logic [N*DW/8-1:0] s_sel_o;
    logic [N-1:0]      s_cyc_o;
    logic [N-1:0]      s_stb_o;
    logic [N*DW-1:0]   s_dat_i;
    logic [N-1:0]      s_ack_i;
    logic [N-1:0]      s_err_i;
    logic              timeout_irq_o;
    logic [AW-1:0]     err_addr_o;
    logic [15:0]       err_count_o;
    logic              err_clr_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave 1 window widened to 128 KiB so it overlaps slave 2 at 0x4001_0000
    wb_data_interconnect #(
        .N_SLAVES       (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .SLV_BASE       ({32'h4003_0000, 32'h4002_0000, 32'h4001_0000, 32'h4000_0000, 32'h0000_0000}),
        .SLV_MASK       ({32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFE_0000, 32'hE000_0000}),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m_adr_i       (m_adr_i),
        .m_dat_i       (m_dat_i),
        .m_we_i        (m_we_i),
        .m_sel_i       (m_sel_i),
        .m_cyc_i       (m_cyc_i),
        .m_stb_i       (m_stb_i),
        .m_dat_o       (m_dat_o),
        .m_ack_o       (m_ack_o),
        .m_err_o       (m_err_o),
        .s_adr_o       (s_adr_o),
        .s_dat_o       (s_dat_o),
        .s_we_o        (s_we_o),
        .s_sel_o       (s_sel_o),
        .s_cyc_o       (s_cyc_o),
        .s_stb_o       (s_stb_o),
        .s_dat_i       (s_dat_i),
        .s_ack_i       (s_ack_i),
        .s_err_i       (s_err_i),
        .timeout_irq_o (timeout_irq_o),
        .err_addr_o    (err_addr_o),
        .err_count_o   (err_count_o),
        .err_clr_i     (err_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [3:0] sel);
        m_adr_i = a;
        m_dat_i = d;
        m_we_i  = we;
        m_sel_i = sel;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
    endtask

    task automatic rel();
        m_adr_i = '0;
        m_dat_i = '0;
        m_we_i  = 1'b0;
        m_sel_i = '0;
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++; if (m_ack_o !== 1'b0 || m_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_resp: ack=%b err=%b want 0 0", m_ack_o, m_err_o); end
        n_cmp++; if (m_dat_o !== 32'h0) begin n_bad++; $display("FAIL rst_dat: got %h want 0", m_dat_o); end
        n_cmp++; if (s_cyc_o !== 5'b0 || s_stb_o !== 5'b0) begin n_bad++; $display("FAIL rst_strobes: cyc=%b stb=%b want 0", s_cyc_o, s_stb_o); end
        n_cmp++; if (timeout_irq_o !== 1'b0 || err_addr_o !== 32'h0 || err_count_o !== 16'h0) begin n_bad++; $display("FAIL rst_status: irq=%b addr=%h cnt=%h want 0", timeout_irq_o, err_addr_o, err_count_o); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_read();
        logic [4:0] seen;
        seen = '0;
        tick(); req(32'h0000_0100, 32'h0, 1'b0, 4'hF);                 // c0
        @(negedge clk); seen = seen | s_stb_o;
        tick();                                                        // c1
        @(negedge clk); seen = seen | s_stb_o;
        n_cmp++; if (s_stb_o !== 5'b00001) begin n_bad++; $display("FAIL rd_stb_c1: got %b want 00001", s_stb_o); end
        tick(); s_ack_i[0] = 1'b1; s_dat_i[31:0] = 32'hDEAD_BEEF;      // c2
        @(negedge clk); seen = seen | s_stb_o;
        n_cmp++; if (m_ack_o !== 1'b0) begin n_bad++; $display("FAIL rd_ack_early: got %b want 0", m_ack_o); end
        tick(); s_ack_i = '0; rel();                                   // c3
        @(negedge clk); seen = seen | s_stb_o;
        n_cmp++; if (m_ack_o !== 1'b1) begin n_bad++; $display("FAIL rd_ack_c3: got %b want 1", m_ack_o); end
        n_cmp++; if (m_dat_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_dat: got %h want deadbeef", m_dat_o); end
        tick();                                                        // c4
        @(negedge clk);
        n_cmp++; if (m_ack_o !== 1'b0) begin n_bad++; $display("FAIL rd_ack_pulse: got %b want 0", m_ack_o); end
        n_cmp++; if (seen !== 5'b00001) begin n_bad++; $display("FAIL rd_only_slave0: got %b want 00001", seen); end
    endtask

    task automatic test_ack_err();
        tick(); req(32'h0000_0200, 32'h0, 1'b0, 4'hF);                 // c0
        tick(); s_ack_i[0] = 1'b1; s_err_i[0] = 1'b1; s_dat_i[31:0] = 32'hCAFE_F00D; // c1
        tick(); s_ack_i = '0; s_err_i = '0; rel();                     // c2
        @(negedge clk);
        n_cmp++; if (m_err_o !== 1'b1 || m_ack_o !== 1'b0) begin n_bad++; $display("FAIL ackerr_resp: err=%b ack=%b want 1 0", m_err_o, m_ack_o); end
        n_cmp++; if (m_dat_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ackerr_dat: got %h want deadbeef", m_dat_o); end
        tick();                                                        // c3
        @(negedge clk);
        n_cmp++; if (err_count_o !== 16'd0) begin n_bad++; $display("FAIL ackerr_cnt: got %0d want 0", err_count_o); end
    endtask

    task automatic test_write();
        tick(); req(32'h4002_0004, 32'h1234_5678, 1'b1, 4'hC);         // c0
        tick(); s_ack_i[3] = 1'b1; s_dat_i[127:96] = 32'h0BAD_F00D;    // c1
        @(negedge clk);
        n_cmp++; if (s_stb_o !== 5'b01000 || s_cyc_o !== 5'b01000) begin n_bad++; $display("FAIL wr_strobe: stb=%b cyc=%b want 01000", s_stb_o, s_cyc_o); end
        n_cmp++; if (s_adr_o !== {32'h0, 32'h4002_0004, 96'h0}) begin n_bad++; $display("FAIL wr_adr: got %h", s_adr_o); end
        n_cmp++; if (s_dat_o !== {32'h0, 32'h1234_5678, 96'h0}) begin n_bad++; $display("FAIL wr_dat: got %h", s_dat_o); end
        n_cmp++; if (s_we_o !== 5'b01000 || s_sel_o !== {4'h0, 4'hC, 12'h0}) begin n_bad++; $display("FAIL wr_we_sel: we=%b sel=%h want 01000 0c000", s_we_o, s_sel_o); end
        tick(); s_ack_i = '0; rel();                                   // c2
        @(negedge clk);
        n_cmp++; if (m_ack_o !== 1'b1 || m_err_o !== 1'b0) begin n_bad++; $display("FAIL wr_ack: ack=%b err=%b want 1 0", m_ack_o, m_err_o); end
        n_cmp++; if (s_stb_o !== 5'b0) begin n_bad++; $display("FAIL wr_resp_stb: got %b want 0", s_stb_o); end
        tick();
    endtask

    task automatic test_decerr();
        tick(); req(32'h8000_0000, 32'h0, 1'b0, 4'hF);                 // c0
        tick();                                                        // c1
        @(negedge clk);
        n_cmp++; if (m_err_o !== 1'b1) begin n_bad++; $display("FAIL dec_err_c1: got %b want 1", m_err_o); end
        n_cmp++; if (s_cyc_o !== 5'b0) begin n_bad++; $display("FAIL dec_no_slave: got %b want 0", s_cyc_o); end
        tick(); rel();                                                 // c2
        @(negedge clk);
        n_cmp++; if (m_err_o !== 1'b0) begin n_bad++; $display("FAIL dec_err_pulse: got %b want 0", m_err_o); end
        n_cmp++; if (err_addr_o !== 32'h8000_0000) begin n_bad++; $display("FAIL dec_addr: got %h want 80000000", err_addr_o); end
        n_cmp++; if (err_count_o !== 16'd1) begin n_bad++; $display("FAIL dec_cnt: got %0d want 1", err_count_o); end
    endtask

    task automatic test_timeout();
        tick(); req(32'h4000_0020, 32'h0, 1'b0, 4'hF);                 // c0
        for (int c = 0; c <= 11; c++) begin
            if (c > 0) tick();
            if (c == 11) rel();
            @(negedge clk);
            if (c >= 1 && c <= 9) begin
                n_cmp++; if (s_stb_o !== 5'b00010 || m_err_o !== 1'b0 || timeout_irq_o !== 1'b0) begin n_bad++; $display("FAIL tmo_wait c%0d: stb=%b err=%b irq=%b want 00010 0 0", c, s_stb_o, m_err_o, timeout_irq_o); end
            end else if (c == 10) begin
                n_cmp++; if (s_stb_o !== 5'b0 || m_err_o !== 1'b1 || timeout_irq_o !== 1'b1) begin n_bad++; $display("FAIL tmo_fire c10: stb=%b err=%b irq=%b want 00000 1 1", s_stb_o, m_err_o, timeout_irq_o); end
            end else if (c == 11) begin
                n_cmp++; if (m_err_o !== 1'b0 || timeout_irq_o !== 1'b0) begin n_bad++; $display("FAIL tmo_pulse c11: err=%b irq=%b want 0 0", m_err_o, timeout_irq_o); end
            end
        end
        n_cmp++; if (err_addr_o !== 32'h4000_0020) begin n_bad++; $display("FAIL tmo_addr: got %h want 40000020", err_addr_o); end
        n_cmp++; if (err_count_o !== 16'd2) begin n_bad++; $display("FAIL tmo_cnt: got %0d want 2", err_count_o); end
    endtask

    task automatic test_abort();
        tick(); req(32'h4003_0010, 32'h0, 1'b0, 4'hF);                 // c0
        tick();                                                        // c1
        @(negedge clk);
        n_cmp++; if (s_stb_o !== 5'b10000) begin n_bad++; $display("FAIL abort_stb_c1: got %b want 10000", s_stb_o); end
        tick(); rel();                                                 // c2
        @(negedge clk);
        n_cmp++; if (s_cyc_o !== 5'b0 || s_stb_o !== 5'b0) begin n_bad++; $display("FAIL abort_drop: cyc=%b stb=%b want 0", s_cyc_o, s_stb_o); end
        for (int c = 3; c <= 4; c++) begin
            tick();
            @(negedge clk);
            n_cmp++; if (m_ack_o !== 1'b0 || m_err_o !== 1'b0) begin n_bad++; $display("FAIL abort_noresp c%0d: ack=%b err=%b want 0 0", c, m_ack_o, m_err_o); end
        end
        n_cmp++; if (err_count_o !== 16'd2) begin n_bad++; $display("FAIL abort_cnt: got %0d want 2", err_count_o); end
    endtask

    task automatic test_overlap();
        tick(); req(32'h4001_0000, 32'h0, 1'b0, 4'hF);                 // c0
        tick(); s_ack_i[2] = 1'b1; s_dat_i[95:64] = 32'h9999_9999;     // c1
        @(negedge clk);
        n_cmp++; if (s_stb_o !== 5'b00010) begin n_bad++; $display("FAIL ovl_grant: got %b want 00010", s_stb_o); end
        tick(); s_ack_i = '0; s_ack_i[1] = 1'b1; s_dat_i[63:32] = 32'h1111_2222; // c2
        @(negedge clk);
        n_cmp++; if (m_ack_o !== 1'b0) begin n_bad++; $display("FAIL ovl_foreign_ack: got %b want 0", m_ack_o); end
        tick(); s_ack_i = '0; rel();                                   // c3
        @(negedge clk);
        n_cmp++; if (m_ack_o !== 1'b1 || m_dat_o !== 32'h1111_2222) begin n_bad++; $display("FAIL ovl_resp: ack=%b dat=%h want 1 11112222", m_ack_o, m_dat_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        tick(); req(32'h0000_0010, 32'h0, 1'b0, 4'hF);                 // c0
        tick(); s_ack_i[0] = 1'b1; s_dat_i[31:0] = 32'h0000_00A1;      // c1
        @(negedge clk);
        n_cmp++; if (s_stb_o !== 5'b00001) begin n_bad++; $display("FAIL b2b_stb1: got %b want 00001", s_stb_o); end
        tick(); s_ack_i = '0;                                          // c2
        @(negedge clk);
        n_cmp++; if (m_ack_o !== 1'b1 || m_dat_o !== 32'h0000_00A1) begin n_bad++; $display("FAIL b2b_resp1: ack=%b dat=%h want 1 a1", m_ack_o, m_dat_o); end
        tick(); req(32'h0000_0020, 32'h0, 1'b0, 4'hF);                 // c3
        @(negedge clk);
        n_cmp++; if (s_stb_o !== 5'b0 || m_ack_o !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: stb=%b ack=%b want 0 0", s_stb_o, m_ack_o); end
        tick(); s_ack_i[0] = 1'b1; s_dat_i[31:0] = 32'h0000_00A2;      // c4
        @(negedge clk);
        n_cmp++; if (s_stb_o !== 5'b00001 || s_adr_o[31:0] !== 32'h0000_0020) begin n_bad++; $display("FAIL b2b_stb2: stb=%b adr=%h want 00001 20", s_stb_o, s_adr_o[31:0]); end
        tick(); s_ack_i = '0; rel();                                   // c5
        @(negedge clk);
        n_cmp++; if (m_ack_o !== 1'b1 || m_dat_o !== 32'h0000_00A2) begin n_bad++; $display("FAIL b2b_resp2: ack=%b dat=%h want 1 a2", m_ack_o, m_dat_o); end
        tick();
    endtask

    task automatic test_err_clr();
        tick(); req(32'hA000_0000, 32'h0, 1'b0, 4'hF); err_clr_i = 1'b1; // c0: clear coincides with fault
        tick(); err_clr_i = 1'b0;                                      // c1
        @(negedge clk);
        n_cmp++; if (m_err_o !== 1'b1) begin n_bad++; $display("FAIL clr_dec_err: got %b want 1", m_err_o); end
        tick(); rel();                                                 // c2
        @(negedge clk);
        n_cmp++; if (err_count_o !== 16'd1 || err_addr_o !== 32'hA000_0000) begin n_bad++; $display("FAIL clr_coincident: cnt=%0d addr=%h want 1 a0000000", err_count_o, err_addr_o); end
        tick(); err_clr_i = 1'b1;                                      // c3
        tick(); err_clr_i = 1'b0;                                      // c4
        @(negedge clk);
        n_cmp++; if (err_count_o !== 16'd0) begin n_bad++; $display("FAIL clr_plain: got %0d want 0", err_count_o); end
    endtask

    task automatic test_reset_mid();
        tick(); req(32'h0000_0300, 32'h0, 1'b0, 4'hF);                 // c0
        tick();                                                        // c1
        @(negedge clk);
        n_cmp++; if (s_stb_o !== 5'b00001) begin n_bad++; $display("FAIL rstmid_stb: got %b want 00001", s_stb_o); end
        tick(); rst = 1'b1; s_ack_i[0] = 1'b1; s_dat_i[31:0] = 32'h5555_AAAA; // c2
        tick(); rst = 1'b0; s_ack_i = '0; rel();                       // c3
        @(negedge clk);
        n_cmp++; if (s_stb_o !== 5'b0 || s_cyc_o !== 5'b0) begin n_bad++; $display("FAIL rstmid_strobes: stb=%b cyc=%b want 0", s_stb_o, s_cyc_o); end
        n_cmp++; if (m_ack_o !== 1'b0 || m_err_o !== 1'b0 || timeout_irq_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_resp: ack=%b err=%b irq=%b want 0", m_ack_o, m_err_o, timeout_irq_o); end
        n_cmp++; if (m_dat_o !== 32'h0 || err_addr_o !== 32'h0 || err_count_o !== 16'h0) begin n_bad++; $display("FAIL rstmid_regs: dat=%h addr=%h cnt=%h want 0", m_dat_o, err_addr_o, err_count_o); end
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        err_clr_i = 1'b0;
        s_dat_i   = '0;
        s_ack_i   = '0;
        s_err_i   = '0;
        rel();
        test_reset();
        test_read();
        test_ack_err();
        test_write();
        test_decerr();
        test_timeout();
        test_abort();
        test_overlap();
        test_back_to_back();
        test_err_clr();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
